// File: rtl/rvfi_pkg.sv
// RVFI retirement record type shared by the core trace port and its consumers.
package rvfi_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_rdata;
    logic [63:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rmask;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic [63:0] mem_wdata;
  } rvfi_instr_t;

endpackage

// File: rtl/rvfi_commit_serializer_if.sv
// Bundle between the core's RVFI commit ports, the serializer and its single-stream consumer.
interface rvfi_commit_serializer_if #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i;
  rvfi_pkg::rvfi_instr_t                       rvfi_o;

  // Handshake: a record transfers on a cycle where valid_o && ready_i at posedge.
  // Once valid_o is high, rvfi_o/seq_o hold steady until that transfer; only reset
  // may drop valid_o early. ready_i may toggle freely and never feeds the outputs.
  logic        valid_o;
  logic        ready_i;
  logic [63:0] seq_o;
  logic [CW-1:0] count_o;
  logic        overflow_o;
  logic [31:0] drop_cnt_o;

  modport master (
    output rvfi_i, ready_i,
    input  rvfi_o, valid_o, seq_o, count_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  rvfi_i, ready_i,
    output rvfi_o, valid_o, seq_o, count_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/rvfi_commit_serializer.sv
// Collects RVFI records from all commit ports into a FIFO and re-emits them one per
// cycle in program order, tagged with a retire sequence number; overflow drops are counted.
module rvfi_commit_serializer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  rvfi_commit_serializer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = PW + 2;

  rvfi_pkg::rvfi_instr_t r_mem     [DEPTH];
  logic [63:0]           r_seq_mem [DEPTH];

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_seq_cnt;
  logic          r_overflow;
  logic [31:0]   r_drop_cnt;

  logic                       w_valid;
  logic                       w_pop;
  logic [FW-1:0]              w_free;
  logic [NR_COMMIT_PORTS-1:0] w_wr_en;
  logic [PW-1:0]              w_wr_idx [NR_COMMIT_PORTS];
  logic [63:0]                w_wr_seq [NR_COMMIT_PORTS];
  logic [2:0]                 w_n_push;
  logic [2:0]                 w_n_drop;
  logic [32:0]                w_drop_sum;

  // Live ports are packed in port order; once free slots run out the rest are dropped.
  always_comb begin
    w_valid  = (r_count != '0);
    w_pop    = w_valid & bus.ready_i;
    w_free   = FW'(DEPTH) - FW'(r_count) + FW'(w_pop);
    w_n_push = '0;
    w_n_drop = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      w_wr_en[p]  = 1'b0;
      w_wr_idx[p] = r_wptr + PW'(w_n_push);
      w_wr_seq[p] = r_seq_cnt + 64'(w_n_push);
      if (bus.rvfi_i[p].valid || bus.rvfi_i[p].trap) begin
        if (FW'(w_n_push) < w_free) begin
          w_wr_en[p] = 1'b1;
          w_n_push   = w_n_push + 3'd1;
        end else begin
          w_n_drop   = w_n_drop + 3'd1;
        end
      end
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_n_drop);
  end

  // Storage is intentionally left unreset; the outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (w_wr_en[p]) begin
        r_mem[w_wr_idx[p]]     <= bus.rvfi_i[p];
        r_seq_mem[w_wr_idx[p]] <= w_wr_seq[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_seq_cnt  <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wptr    <= r_wptr + PW'(w_n_push);
      r_seq_cnt <= r_seq_cnt + 64'(w_n_push);
      r_count   <= r_count + CW'(w_n_push) - CW'(w_pop);
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_n_drop != '0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      end
    end
  end

  assign bus.valid_o    = w_valid;
  assign bus.rvfi_o     = w_valid ? r_mem[r_rptr] : '0;
  assign bus.seq_o      = w_valid ? r_seq_mem[r_rptr] : 64'd0;
  assign bus.count_o    = r_count;
  assign bus.overflow_o = r_overflow;
  assign bus.drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed bench for rvfi_commit_serializer: ordering, compaction, traps, overflow, reset.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  always #5 clk_i = ~clk_i;

  rvfi_commit_serializer_if #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) bus();

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] pc);
    rvfi_instr_t r;
    r          = '0;
    r.valid    = v;
    r.trap     = t;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 64'd4;
    r.insn     = pc[31:0] ^ 32'h0000_0013;
    r.order    = pc;
    r.rd_wdata = ~pc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input rvfi_instr_t r0, input rvfi_instr_t r1);
    bus.rvfi_i[0] = r0;
    bus.rvfi_i[1] = r1;
  endtask

  task automatic idle();
    drive('0, '0);
  endtask

  task automatic do_reset();
    idle();
    bus.ready_i = 1'b0;
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic expect_head(input string tag, input rvfi_instr_t r, input logic [63:0] seq);
    check({tag, " valid"}, 64'(bus.valid_o), 64'd1);
    check({tag, " pc"}, bus.rvfi_o.pc_rdata, r.pc_rdata);
    check({tag, " seq"}, bus.seq_o, seq);
    check({tag, " rec"}, 64'(bus.rvfi_o == r), 64'd1);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, " valid"}, 64'(bus.valid_o), 64'd0);
    check({tag, " rvfi_zero"}, 64'(bus.rvfi_o == '0), 64'd1);
    check({tag, " seq"}, bus.seq_o, 64'd0);
  endtask

  // Two live records per cycle for n cycles, pcs base, base+4, ...; ready held low.
  task automatic fill_pairs(input int n, input logic [63:0] base);
    bus.ready_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      drive(mk(1'b1, 1'b0, base + 64'(8 * c)), mk(1'b1, 1'b0, base + 64'(8 * c + 4)));
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    bus.ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #15;
    expect_empty("reset");
    check("reset count", 64'(bus.count_o), 64'd0);
    check("reset ovf", 64'(bus.overflow_o), 64'd0);
    check("reset drop", 64'(bus.drop_cnt_o), 64'd0);
    #2 rst_ni = 1'b1;
    tick();

    // Single record, one-cycle latency
    drive(mk(1'b1, 1'b0, 64'h8000_0000), '0);
    bus.ready_i = 1'b1;
    check("single pre_edge valid", 64'(bus.valid_o), 64'd0);
    tick();
    idle();
    expect_head("single", mk(1'b1, 1'b0, 64'h8000_0000), 64'd0);
    check("single count", 64'(bus.count_o), 64'd1);
    tick();
    expect_empty("single drained");
    check("single drained count", 64'(bus.count_o), 64'd0);

    // Ordering and compaction
    do_reset();
    bus.ready_i = 1'b1;
    drive(mk(1'b1, 1'b0, 64'h100), mk(1'b1, 1'b0, 64'h104));
    tick();
    drive('0, mk(1'b1, 1'b0, 64'h108));
    expect_head("order0", mk(1'b1, 1'b0, 64'h100), 64'd0);
    tick();
    idle();
    expect_head("order1", mk(1'b1, 1'b0, 64'h104), 64'd1);
    check("order1 count", 64'(bus.count_o), 64'd2);
    tick();
    expect_head("order2", mk(1'b1, 1'b0, 64'h108), 64'd2);
    tick();
    expect_empty("order done");

    // Trap-only record; port 1 non-live with junk fields
    do_reset();
    begin
      rvfi_instr_t junk;
      junk = mk(1'b0, 1'b0, 64'h204);
      drive(mk(1'b0, 1'b1, 64'h200), junk);
    end
    tick();
    idle();
    check("trap count", 64'(bus.count_o), 64'd1);
    expect_head("trap", mk(1'b0, 1'b1, 64'h200), 64'd0);
    check("trap bit", 64'(bus.rvfi_o.trap), 64'd1);
    tick();
    check("trap hold count", 64'(bus.count_o), 64'd1);
    expect_head("trap hold", mk(1'b0, 1'b1, 64'h200), 64'd0);
    bus.ready_i = 1'b1;
    tick();
    check("trap popped count", 64'(bus.count_o), 64'd0);

    // Overflow: 10 offered, 8 kept
    do_reset();
    fill_pairs(4, 64'h1000);
    check("ovf pre count", 64'(bus.count_o), 64'd8);
    check("ovf pre flag", 64'(bus.overflow_o), 64'd0);
    fill_pairs(1, 64'h1020);
    check("ovf count", 64'(bus.count_o), 64'd8);
    check("ovf flag", 64'(bus.overflow_o), 64'd1);
    check("ovf drop", 64'(bus.drop_cnt_o), 64'd2);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h1000 + 64'(4 * i));
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [63:0] pc;
      pc = exp_q.pop_front();
      expect_head($sformatf("ovf drain%0d", i), mk(1'b1, 1'b0, pc), 64'(i));
      tick();
    end
    expect_empty("ovf drained");
    check("ovf sticky", 64'(bus.overflow_o), 64'd1);

    // Full with simultaneous pop: one push (port 0), one drop
    do_reset();
    fill_pairs(4, 64'h2000);
    bus.ready_i = 1'b1;
    drive(mk(1'b1, 1'b0, 64'h3000), mk(1'b1, 1'b0, 64'h3004));
    tick();
    idle();
    check("fullpop count", 64'(bus.count_o), 64'd8);
    check("fullpop drop", 64'(bus.drop_cnt_o), 64'd1);
    check("fullpop ovf", 64'(bus.overflow_o), 64'd1);
    for (int i = 1; i < 8; i++) begin
      expect_head($sformatf("fullpop drain%0d", i), mk(1'b1, 1'b0, 64'h2000 + 64'(4 * i)), 64'(i));
      tick();
    end
    expect_head("fullpop port0", mk(1'b1, 1'b0, 64'h3000), 64'd8);
    tick();
    expect_empty("fullpop drained");

    // Asynchronous reset with 5 records buffered and overflow set
    do_reset();
    fill_pairs(5, 64'h4000);
    bus.ready_i = 1'b1;
    tick();
    tick();
    tick();
    bus.ready_i = 1'b0;
    check("rst pre count", 64'(bus.count_o), 64'd5);
    check("rst pre ovf", 64'(bus.overflow_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    expect_empty("async rst");
    check("async rst count", 64'(bus.count_o), 64'd0);
    check("async rst ovf", 64'(bus.overflow_o), 64'd0);
    check("async rst drop", 64'(bus.drop_cnt_o), 64'd0);
    #2 rst_ni = 1'b1;
    drive(mk(1'b1, 1'b0, 64'h5000), '0);
    bus.ready_i = 1'b1;
    tick();
    idle();
    expect_head("post rst", mk(1'b1, 1'b0, 64'h5000), 64'd0);
    check("post rst count", 64'(bus.count_o), 64'd1);
    tick();
    expect_empty("post rst drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
